// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub
//   Sequential unsigned subtractor. It computes a 4*NIB-bit difference one
//   nibble per clock, using a single 4-bit ripple full-subtract slice. The
//   borrow is carried between nibbles in a register.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : begin an operation; accepted only while ready is high
//   a, b   : minuend and subtrahend, sampled on the accepting edge
//   ready  : high while idle
//   done   : one-cycle pulse; diff/borrow/zero are newly valid
//   diff   : (a - b) mod 2^W
//   borrow : 1 iff a < b (unsigned)
//   zero   : 1 iff diff == 0
module nibble_serial_sub #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [4*NIB-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, nstate;

    logic [W-1:0]  opa, opb, wres, res_next;
    logic [IW-1:0] idx;
    logic          bq;
    logic [3:0]    x, y, dn;
    logic [4:0]    bc;

    // Nibble slice: ripple full-subtract of x - y - bq.
    always_comb begin
        x  = opa[{idx, 2'b00} +: 4];
        y  = opb[{idx, 2'b00} +: 4];
        dn = '0;
        bc = '0;
        bc[0] = bq;
        for (int unsigned i = 0; i < 4; i++) begin
            dn[i]   = x[i] ^ y[i] ^ bc[i];
            bc[i+1] = (~x[i] & y[i]) | (y[i] & bc[i]) | (bc[i] & ~x[i]);
        end
        // Working result with the current nibble merged in, so the final
        // zero test sees the complete word on the edge that enters DONE.
        res_next = wres;
        res_next[{idx, 2'b00} +: 4] = dn;
    end

    always_comb begin
        nstate = state;
        ready  = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) nstate = RUN;
            end
            RUN: begin
                if (idx == LAST) nstate = DONE;
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            wres   <= '0;
            idx    <= '0;
            bq     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa  <= a;
                        opb  <= b;
                        wres <= '0;
                        idx  <= '0;
                        bq   <= 1'b0;
                    end
                end
                RUN: begin
                    wres <= res_next;
                    bq   <= bc[4];
                    idx  <= idx + 1'b1;
                    if (idx == LAST) begin
                        diff   <= res_next;
                        borrow <= bc[4];
                        zero   <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
